cache_refill_ctrl: RTL and testbench
====================================

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of the saturating miss counter.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: cpu_req  input  1  a lookup is presented to the cache this cycle.
REQ-005 Port: cpu_addr  input  32  lookup byte address; [31:5] is the block address.
REQ-006 Port: cache_hit  input  1  hit result from the cache for the current lookup.
REQ-007 Port: mem_req  output  1  block read request to memory.
REQ-008 Port: mem_addr  output  32  block-aligned read address; [4:0] always zero.
REQ-009 Port: mem_gnt  input  1  memory accepts the request.
REQ-010 Port: mem_rvalid  input  1  one 32-bit read beat is valid on mem_rdata.
REQ-011 Port: mem_rdata  input  32  read beat data.
REQ-012 Port: fill_en  output  1  one-cycle pulse; cache writes fill_block into the victim line.
REQ-013 Port: fill_block  output  256  assembled 32-byte line.
REQ-014 Port: stall  output  1  processor must hold cpu_addr and retry the lookup.
REQ-015 Port: miss_count  output  CNT_W  number of misses serviced since reset.

Function
REQ-016 The controller SHALL be a Moore FSM with states IDLE, REQ, BURST, FILL and SETTLE.
REQ-017 IDLE: cpu_req=1 and cache_hit=0 SHALL latch cpu_addr[31:5] and move to REQ next cycle.
REQ-018 IDLE: cpu_req=0 or cache_hit=1 SHALL remain in IDLE.
REQ-019 REQ: mem_req=1, with mem_addr = {latched[31:5], 5'b0}.
REQ-020 REQ: mem_req and mem_addr SHALL stay stable until the cycle mem_gnt=1, then move to BURST with beat counter = 0.
REQ-021 BURST: each cycle with mem_rvalid=1 SHALL write mem_rdata into fill_block[32k+31:32k], where k is a 3-bit beat counter.
REQ-022 BURST: k SHALL increment per beat; the beat with k=7 SHALL move to FILL.
REQ-023 mem_rvalid SHALL be ignored outside BURST, and gaps between beats are legal.
REQ-024 FILL: fill_en=1 for exactly one cycle, then move to SETTLE.
REQ-025 SETTLE: one cycle with fill_en=0, then return to IDLE, where the retried lookup hits.
REQ-026 stall SHALL be combinational: (state != IDLE) OR (cpu_req AND NOT cache_hit).
REQ-027 miss_count SHALL increment on each IDLE->REQ transition and saturate at all-ones.
REQ-028 fill_block SHALL hold its value from FILL until the first beat of the next miss.
REQ-029 Changes on cpu_addr or cache_hit outside IDLE SHALL be ignored.
REQ-030 A miss detected in IDLE in the cycle SETTLE exits SHALL be serviced normally, with no lost or duplicated request.
REQ-031 Miss-to-fill_en latency with mem_gnt and mem_rvalid held high SHALL be 10 cycles: 1 REQ + 8 BURST + FILL.

Reset
REQ-032 reset=1 on a clock edge SHALL force IDLE, beat counter 0, latched address 0, fill_block 0 and miss_count 0.
REQ-033 While in reset or IDLE: mem_req=0, mem_addr=0, fill_en=0.
REQ-034 Reset asserted in any state, including mid-burst, SHALL abort the transfer.
REQ-035 After such an abort, no fill_en SHALL be produced for it, and stale beats arriving later SHALL be ignored.
REQ-036 reset SHALL take priority over every other input in the same cycle.

Verification
REQ-037 Reset: assert reset 2 cycles -> mem_req=0, fill_en=0, fill_block=0, miss_count=0, stall=0 with cpu_req=0.
REQ-038 Read miss: cpu_addr=32'h00A00062, cache_hit=0, mem_gnt=1, beats 32'h11111111..32'h88888888 back-to-back.
  -> mem_addr=32'h00A00060.
  -> fill_en pulses 10 cycles after the miss, with fill_block[31:0]=32'h11111111 and [255:224]=32'h88888888.
  -> miss_count=1; stall low in the cycle after SETTLE.
REQ-039 Hit: cpu_req=1, cache_hit=1 -> stall=0, mem_req never asserts, miss_count unchanged.
REQ-040 Grant delay and beat gaps: mem_gnt held low 3 cycles, one idle cycle between each beat.
  -> mem_addr stable throughout REQ.
  -> Exactly 8 beats captured in order and one fill_en.
  -> cpu_addr changed during BURST has no effect.
REQ-041 Reset mid-burst: reset after beat 4, then 4 more mem_rvalid beats -> no fill_en, state IDLE, fill_block=0.
REQ-042 Back-to-back misses and saturation.
  -> A second miss presented on the SETTLE-exit cycle produces a second request with the new mem_addr, and miss_count=2.
  -> With CNT_W=2, a 5th miss leaves miss_count=3.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl
//   Single-line refill controller for a blocking cache. A lookup miss in IDLE
//   latches the block address, requests the 32-byte block from memory, collects
//   eight 32-bit beats into fill_block and then pulses fill_en so the cache can
//   write the victim line. The processor is stalled until the controller is back
//   in IDLE, where its retried lookup hits.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   cpu_req/cpu_addr  lookup strobe and byte address ([31:5] = block address)
//   cache_hit         hit result for the current lookup
//   mem_req/mem_addr  block read request and block-aligned address (registered)
//   mem_gnt           memory accepted the request
//   mem_rvalid/rdata  one 32-bit read beat per valid cycle
//   fill_en           one-cycle line-write strobe (registered)
//   fill_block        assembled 256-bit line, held until the next miss overwrites it
//   stall             combinational hold for the processor
//   miss_count        saturating count of serviced misses
module cache_refill_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic [31:0]      cpu_addr,
  input  logic             cache_hit,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  output logic             fill_en,
  output logic [255:0]     fill_block,
  output logic             stall,
  output logic [CNT_W-1:0] miss_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_BURST,
    ST_FILL,
    ST_SETTLE
  } state_t;

  state_t             state_q, state_d;
  logic [26:0]        blk_q, blk_d;
  logic [2:0]         beat_q, beat_d;
  logic [255:0]       fill_block_q, fill_block_d;
  logic [CNT_W-1:0]   miss_count_q, miss_count_d;
  logic               mem_req_q, mem_req_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic               fill_en_q, fill_en_d;

  // Byte offset within the block never matters to a whole-line refill.
  logic               addr_offset_unused;
  assign addr_offset_unused = ^cpu_addr[4:0];

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_d      = state_q;
    blk_d        = blk_q;
    beat_d       = beat_q;
    fill_block_d = fill_block_q;
    miss_count_d = miss_count_q;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req && !cache_hit) begin
          blk_d   = cpu_addr[31:5];
          state_d = ST_REQ;
          if (miss_count_q != '1) begin
            miss_count_d = miss_count_q + CNT_W'(1);
          end
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          beat_d  = '0;
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        // Beats may arrive with gaps; only valid cycles advance the slot index.
        if (mem_rvalid) begin
          fill_block_d[{beat_q, 5'b00000} +: 32] = mem_rdata;
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) begin
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state and registered, so they line up
    // exactly with the state they describe.
    mem_req_d  = (state_d == ST_REQ);
    mem_addr_d = mem_req_d ? {blk_d, 5'b00000} : '0;
    fill_en_d  = (state_d == ST_FILL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      blk_q        <= '0;
      beat_q       <= '0;
      fill_block_q <= '0;
      miss_count_q <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      fill_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      blk_q        <= blk_d;
      beat_q       <= beat_d;
      fill_block_q <= fill_block_d;
      miss_count_q <= miss_count_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      fill_en_q    <= fill_en_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign fill_en    = fill_en_q;
  assign fill_block = fill_block_q;
  assign miss_count = miss_count_q;
  assign stall      = (state_q != ST_IDLE) || (cpu_req && !cache_hit);

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl
//   Directed-plus-random bench for cache_refill_ctrl. A second instance with a
//   2-bit miss counter shares the stimulus so counter saturation is observed
//   alongside the default-width instance.
module tb_cache_refill_ctrl;

  logic         clk;
  logic         reset;
  logic         cpu_req;
  logic [31:0]  cpu_addr;
  logic         cache_hit;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_gnt;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;
  logic         fill_en;
  logic [255:0] fill_block;
  logic         stall;
  logic [15:0]  miss_count;

  logic         s_mem_req;
  logic [31:0]  s_mem_addr;
  logic         s_fill_en;
  logic [255:0] s_fill_block;
  logic         s_stall;
  logic [1:0]   s_miss_count;

  int unsigned  checks;
  int unsigned  errors;

  // Reference state: number of misses since reset and the last completed line.
  int unsigned  exp_cnt;
  logic [255:0] exp_block;

  cache_refill_ctrl #(.CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cache_hit  (cache_hit),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .fill_en    (fill_en),
    .fill_block (fill_block),
    .stall      (stall),
    .miss_count (miss_count)
  );

  cache_refill_ctrl #(.CNT_W(2)) dut_sat (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cache_hit  (cache_hit),
    .mem_req    (s_mem_req),
    .mem_addr   (s_mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .fill_en    (s_fill_en),
    .fill_block (s_fill_block),
    .stall      (s_stall),
    .miss_count (s_miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned sat3(input int unsigned n);
    return (n > 3) ? 3 : n;
  endfunction

  task automatic chk_counts(input string tag);
    chk({tag, "_cnt"}, 256'(miss_count), 256'(exp_cnt));
    chk({tag, "_cnt_sat"}, 256'(s_miss_count), 256'(sat3(exp_cnt)));
  endtask

  // Lookup-side inputs are don't-care while the controller is busy.
  task automatic scramble();
    cpu_req   = 1'($urandom_range(1, 0));
    cache_hit = 1'($urandom_range(1, 0));
    cpu_addr  = $urandom;
  endtask

  // Services one miss starting in an IDLE cycle; returns positioned in SETTLE.
  task automatic do_miss(input logic [31:0] addr, input int unsigned gnt_delay,
                         input int unsigned min_gap, input int unsigned max_gap,
                         input bit rand_beats);
    logic [255:0] blk;
    logic [31:0]  w;
    logic [31:0]  exp_addr;
    int unsigned  gap;
    blk      = exp_block;
    exp_addr = addr & 32'hFFFF_FFE0;

    cpu_req    = 1'b1;
    cache_hit  = 1'b0;
    cpu_addr   = addr;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    chk("miss_stall", 256'(stall), 256'(1));
    chk("idle_mem_req", 256'(mem_req), 256'(0));
    chk_counts("pre_miss");
    tick();
    if (exp_cnt < 65535) exp_cnt++;

    for (int unsigned g = 0; g <= gnt_delay; g++) begin
      scramble();
      mem_gnt    = (g == gnt_delay);
      mem_rvalid = 1'($urandom_range(1, 0));
      mem_rdata  = $urandom;
      #1;
      chk("req_mem_req", 256'(mem_req), 256'(1));
      chk("req_mem_addr", 256'(mem_addr), 256'(exp_addr));
      chk("req_stall", 256'(stall), 256'(1));
      chk("req_fill_en", 256'(fill_en), 256'(0));
      chk_counts("req");
      tick();
    end
    mem_gnt = 1'b0;

    for (int unsigned b = 0; b < 8; b++) begin
      gap = $urandom_range(max_gap, min_gap);
      for (int unsigned i = 0; i < gap; i++) begin
        scramble();
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        #1;
        chk("burst_fill_en", 256'(fill_en), 256'(0));
        chk("burst_mem_req", 256'(mem_req), 256'(0));
        tick();
      end
      w = rand_beats ? $urandom : 32'h1111_1111 * (b + 1);
      blk[32*b +: 32] = w;
      scramble();
      mem_rvalid = 1'b1;
      mem_rdata  = w;
      #1;
      chk("burst_stall", 256'(stall), 256'(1));
      chk("burst_fill_en", 256'(fill_en), 256'(0));
      tick();
    end

    // Stray beats after the burst must not disturb the assembled line.
    scramble();
    mem_rvalid = 1'b1;
    mem_rdata  = $urandom;
    #1;
    chk("fill_en_pulse", 256'(fill_en), 256'(1));
    chk("fill_block", fill_block, blk);
    chk("fill_mem_req", 256'(mem_req), 256'(0));
    chk("fill_mem_addr", 256'(mem_addr), 256'(0));
    chk_counts("fill");
    tick();
    scramble();
    #1;
    chk("settle_fill_en", 256'(fill_en), 256'(0));
    chk("settle_stall", 256'(stall), 256'(1));
    chk("settle_block", fill_block, blk);
    mem_rvalid = 1'b0;
    exp_block  = blk;
  endtask

  task automatic hit_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      cpu_req    = 1'b1;
      cache_hit  = 1'b1;
      cpu_addr   = $urandom;
      mem_gnt    = 1'($urandom_range(1, 0));
      mem_rvalid = 1'($urandom_range(1, 0));
      mem_rdata  = $urandom;
      #1;
      chk("hit_stall", 256'(stall), 256'(0));
      chk("hit_mem_req", 256'(mem_req), 256'(0));
      chk("hit_fill_en", 256'(fill_en), 256'(0));
      chk("hit_block", fill_block, exp_block);
      chk_counts("hit");
      tick();
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    exp_cnt    = 0;
    exp_block  = '0;
    reset      = 1'b1;
    cpu_req    = 1'b0;
    cpu_addr   = '0;
    cache_hit  = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;

    // Reset held two cycles.
    tick();
    tick();
    chk("rst_mem_req", 256'(mem_req), 256'(0));
    chk("rst_mem_addr", 256'(mem_addr), 256'(0));
    chk("rst_fill_en", 256'(fill_en), 256'(0));
    chk("rst_fill_block", fill_block, 256'(0));
    chk("rst_stall", 256'(stall), 256'(0));
    chk_counts("rst");
    reset = 1'b0;

    // Directed read miss: back-to-back beats, 10-cycle miss-to-fill latency.
    do_miss(32'h00A0_0062, 0, 0, 0, 1'b0);
    chk("dir_word0", 256'(fill_block[31:0]), 256'(32'h1111_1111));
    chk("dir_word7", 256'(fill_block[255:224]), 256'(32'h8888_8888));
    cpu_req   = 1'b1;
    cache_hit = 1'b1;
    tick();
    #1;
    chk("post_settle_stall", 256'(stall), 256'(0));
    chk_counts("post_settle");

    hit_cycles(5);

    // Grant delayed 3 cycles, one idle cycle between every beat.
    do_miss($urandom, 3, 1, 1, 1'b1);
    cpu_req = 1'b0;
    tick();
    hit_cycles(2);

    // Back-to-back: the next miss is presented in the first IDLE cycle after SETTLE.
    do_miss(32'h1234_5678, 1, 0, 0, 1'b1);
    cpu_req   = 1'b1;
    cache_hit = 1'b0;
    cpu_addr  = 32'hCAFE_F00D;
    tick();
    do_miss(32'hCAFE_F00D, 0, 0, 0, 1'b1);
    cpu_req = 1'b0;
    tick();

    // Randomised misses, some back-to-back, some separated by hits.
    for (int unsigned r = 0; r < 6; r++) begin
      do_miss($urandom, $urandom_range(3, 0), 0, $urandom_range(2, 0), 1'b1);
      cpu_req = 1'b0;
      tick();
      if ($urandom_range(1, 0) == 1) hit_cycles($urandom_range(3, 1));
    end
    chk_counts("after_random");

    // Reset after the 4th beat, then stale beats arrive.
    cpu_req   = 1'b1;
    cache_hit = 1'b0;
    cpu_addr  = 32'h0BAD_BEE0;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int unsigned b = 0; b < 4; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
      tick();
    end
    reset      = 1'b1;
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    tick();
    reset     = 1'b0;
    cpu_req   = 1'b0;
    mem_gnt   = 1'b0;
    exp_cnt   = 0;
    exp_block = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
      #1;
      chk("abort_fill_en", 256'(fill_en), 256'(0));
      chk("abort_mem_req", 256'(mem_req), 256'(0));
      chk("abort_stall", 256'(stall), 256'(0));
      chk("abort_block", fill_block, 256'(0));
      chk_counts("abort");
      tick();
    end
    mem_rvalid = 1'b0;
    #1;
    chk("abort_final_fill_en", 256'(fill_en), 256'(0));
    chk("abort_final_block", fill_block, 256'(0));

    // Normal service resumes after the abort.
    do_miss($urandom, 2, 0, 1, 1'b1);
    cpu_req = 1'b0;
    tick();
    chk_counts("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
